// File: rtl/sti_pkg.sv
// Shared types and helpers for the serial pack engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sti_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // pi_length codes: frame is (code+1) pixel units long
  localparam logic [1:0] LEN_1PIX = 2'd0;
  localparam logic [1:0] LEN_2PIX = 2'd1;
  localparam logic [1:0] LEN_3PIX = 2'd2;
  localparam logic [1:0] LEN_4PIX = 2'd3;

  // Frame length in bits for a length code
  function automatic int frame_bits(input logic [1:0] code, input int pix_w);
    case (code)
      LEN_1PIX: return pix_w;
      LEN_2PIX: return 2 * pix_w;
      LEN_3PIX: return 3 * pix_w;
      LEN_4PIX: return 4 * pix_w;
      default:  return pix_w;
    endcase
  endfunction

endpackage

// File: rtl/sti_frame_builder.sv
// Builds the right-aligned F-bit frame word from a parallel word and its options.
// Latency: combinational; the parent registers the result on accept.
// Backpressure: none (pure function of inputs).
// Ports: i_data/i_length/i_low/i_fill in, o_frame out (bits F-1..0 valid, rest 0).
module sti_frame_builder
  import sti_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [1:0]         i_length,
  input  logic               i_low,
  input  logic               i_fill,
  output logic [4*PIX_W-1:0] o_frame
);

  localparam int FMAX = 4 * PIX_W;
  localparam logic [FMAX-1:0] ONES = {FMAX{1'b1}};

  int              w_f;
  logic [FMAX-1:0] w_ext;

  always_comb begin
    w_f     = frame_bits(i_length, PIX_W);
    w_ext   = FMAX'(i_data);
    o_frame = w_ext;
    if (w_f < DATA_W) begin
      // Shorter frame: take either the top or the bottom F bits
      if (i_low) o_frame = w_ext >> (DATA_W - w_f);
      else       o_frame = w_ext & (ONES >> (FMAX - w_f));
    end else if (w_f > DATA_W) begin
      // Longer frame: data either at the MSB end or zero-extended
      if (i_fill) o_frame = w_ext << (w_f - DATA_W);
    end
  end

endmodule

// File: rtl/sti_pack_engine.sv
// Serialises parallel words into 1..4-pixel frames and reassembles pixels into memory writes.
// Latency: first serial bit 1 cycle after accept; pixel k written at accept+(k+1)*PIX_W+1.
// Backpressure: pi_ready high in IDLE and on a frame's last bit (gapless back-to-back), low in FLUSH/DONE.
// Ports: load/pi_* frame request in, pi_ready out; so_data/so_valid serial out;
//        pixel_wr/pixel_addr/pixel_dataout memory write out; pixel_finish sticky image-complete.
module sti_pack_engine
  import sti_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  output logic              pi_ready,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_low,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_end,
  output logic              so_data,
  output logic              so_valid,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_dataout,
  output logic              pixel_finish
);

  localparam int FMAX   = 4 * PIX_W;
  localparam int CNT_W  = $clog2(FMAX);
  localparam int PCNT_W = $clog2(PIX_W);
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  state_t            r_state, w_state_nxt;
  logic [FMAX-1:0]   r_frame;
  logic              r_msb;
  logic [CNT_W-1:0]  r_last, r_cnt;
  logic [PIX_W-1:0]  r_pix;
  logic [PCNT_W-1:0] r_pcnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_full;

  logic [FMAX-1:0]   w_frame;
  logic [CNT_W-1:0]  w_new_last, w_idx0, w_nxt_idx;
  logic              w_accept_load, w_accept_end, w_last_bit;
  logic              w_frame_wr, w_flush_wr, w_wr, w_full_now;

  sti_frame_builder #(.DATA_W(DATA_W), .PIX_W(PIX_W)) u_builder (
    .i_data   (pi_data),
    .i_length (pi_length),
    .i_low    (pi_low),
    .i_fill   (pi_fill),
    .o_frame  (w_frame)
  );

  assign w_new_last = CNT_W'(frame_bits(pi_length, PIX_W) - 1);
  assign w_idx0     = pi_msb ? w_new_last : '0;
  assign w_nxt_idx  = r_msb ? (r_last - r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == r_last);

  // Frames are whole pixels, so a pixel completes on every PIX_W-th valid bit.
  // A completed frame pixel always wins over a flush write.
  assign w_frame_wr = so_valid && (r_pcnt == PCNT_W'(PIX_W - 1)) && !r_full;
  assign w_flush_wr = (r_state == FLUSH) && !w_frame_wr && !r_full;
  assign w_wr       = w_frame_wr || w_flush_wr;
  // Full is known the same edge the last address is written; used to refuse
  // the next frame on a last bit that also fills the image.
  assign w_full_now = r_full || (w_wr && (r_addr == MAX_ADDR));

  assign pi_ready      = !w_full_now && ((r_state == IDLE) || w_last_bit);
  assign w_accept_load = load && pi_ready;
  assign w_accept_end  = pi_end && pi_ready && !load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_full_now)         w_state_nxt = DONE;
        else if (w_accept_load) w_state_nxt = SHIFT;
        else if (w_accept_end)  w_state_nxt = FLUSH;
      end
      SHIFT: begin
        if (w_last_bit) begin
          if (w_full_now)         w_state_nxt = DONE;
          else if (w_accept_load) w_state_nxt = SHIFT;
          else if (w_accept_end)  w_state_nxt = FLUSH;
          else                    w_state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (w_full_now) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame       <= '0;
      r_msb         <= 1'b0;
      r_last        <= '0;
      r_cnt         <= '0;
      so_data       <= 1'b0;
      so_valid      <= 1'b0;
      r_pix         <= '0;
      r_pcnt        <= '0;
      r_addr        <= '0;
      r_full        <= 1'b0;
      pixel_wr      <= 1'b0;
      pixel_addr    <= '0;
      pixel_dataout <= '0;
      pixel_finish  <= 1'b0;
    end else begin
      // Serialiser: the first bit leaves straight from the builder on accept
      if (w_accept_load) begin
        r_frame  <= w_frame;
        r_msb    <= pi_msb;
        r_last   <= w_new_last;
        r_cnt    <= '0;
        so_data  <= w_frame[w_idx0];
        so_valid <= 1'b1;
      end else if ((r_state == SHIFT) && !w_last_bit) begin
        r_cnt    <= r_cnt + CNT_W'(1);
        so_data  <= r_frame[w_nxt_idx];
        so_valid <= 1'b1;
      end else begin
        so_data  <= 1'b0;
        so_valid <= 1'b0;
      end

      // Pixel assembly from the serial stream; first bit ends up as MSB
      if (so_valid) begin
        if (r_pcnt == PCNT_W'(PIX_W - 1)) begin
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + PCNT_W'(1);
          r_pix  <= {r_pix[PIX_W-2:0], so_data};
        end
      end

      pixel_wr <= w_wr;
      if (w_frame_wr) begin
        pixel_addr    <= r_addr;
        pixel_dataout <= {r_pix[PIX_W-2:0], so_data};
      end else if (w_flush_wr) begin
        pixel_addr    <= r_addr;
        pixel_dataout <= '0;
      end

      // Address saturates at the top; the full flag replaces a wrap to 0
      if (w_wr) begin
        if (r_addr == MAX_ADDR) r_full <= 1'b1;
        else                    r_addr <= r_addr + ADDR_W'(1);
      end

      pixel_finish <= r_full;
    end
  end

endmodule

// File: tb/tb_sti_pack_engine.sv
module tb_sti_pack_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        pi_ready;
  logic [15:0] pi_data = '0;
  logic [1:0]  pi_length = '0;
  logic        pi_low = 1'b0;
  logic        pi_fill = 1'b0;
  logic        pi_msb = 1'b0;
  logic        pi_end = 1'b0;
  logic        so_data, so_valid, pixel_wr, pixel_finish;
  logic [7:0]  pixel_addr, pixel_dataout;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int finish_cyc = -1;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  sti_pack_engine #(.DATA_W(16), .PIX_W(8), .ADDR_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .pi_ready      (pi_ready),
    .pi_data       (pi_data),
    .pi_length     (pi_length),
    .pi_low        (pi_low),
    .pi_fill       (pi_fill),
    .pi_msb        (pi_msb),
    .pi_end        (pi_end),
    .so_data       (so_data),
    .so_valid      (so_valid),
    .pixel_wr      (pixel_wr),
    .pixel_addr    (pixel_addr),
    .pixel_dataout (pixel_dataout),
    .pixel_finish  (pixel_finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log sampled on the falling edge
  always @(negedge clk) begin
    if (pixel_wr === 1'b1) begin
      wq_addr.push_back(int'(pixel_addr));
      wq_data.push_back(int'(pixel_dataout));
      wq_cyc.push_back(cyc);
    end
    if (pixel_finish === 1'b1 && finish_cyc < 0) finish_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    finish_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    pi_end = 1'b0;
    step();
    step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic check_write(input string tag, input int k, input int addr, input int data);
    chk({tag, "_addr"}, (k < wq_addr.size()) ? wq_addr[k] : -1, addr);
    chk({tag, "_data"}, (k < wq_data.size()) ? wq_data[k] : -1, data);
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] len, input logic lo,
                      input logic fi, input logic msb);
    pi_data = d; pi_length = len; pi_low = lo; pi_fill = fi; pi_msb = msb;
    load = 1'b1;
    step();
    load = 1'b0;
    pi_data = 16'h0000;
  endtask

  logic [7:0] exp8;
  logic [7:0] exp_d[8];
  int bad;

  initial begin
    // Reset values
    step();
    step();
    chk("rst_so_data", so_data, 0);
    chk("rst_so_valid", so_valid, 0);
    chk("rst_pixel_wr", pixel_wr, 0);
    chk("rst_pixel_addr", pixel_addr, 0);
    chk("rst_pixel_dataout", pixel_dataout, 0);
    chk("rst_pixel_finish", pixel_finish, 0);
    chk("rst_pi_ready", pi_ready, 1);
    reset = 1'b0;
    clear_log();
    step();

    // 8-bit high-half MSB-first frame of A53C
    pi_data = 16'hA53C; pi_length = 2'b00; pi_low = 1'b1; pi_fill = 1'b0; pi_msb = 1'b1;
    load = 1'b1;
    chk("t1_ready_idle", pi_ready, 1);
    step();
    load = 1'b0;
    pi_data = 16'h0000;
    exp8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("t1_so_valid", so_valid, 1);
      chk("t1_so_data", so_data, exp8[7-i]);
      chk("t1_ready", pi_ready, (i == 7) ? 1 : 0);
      step();
    end
    chk("t1_wr", pixel_wr, 1);
    chk("t1_addr", pixel_addr, 0);
    chk("t1_data", pixel_dataout, 8'hA5);
    chk("t1_valid_end", so_valid, 0);
    step();
    chk("t1_wr_pulse", pixel_wr, 0);

    // 16-bit LSB-first frame of 1234, then simultaneous load and pi_end
    do_reset();
    send(16'h1234, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (18) step();
    chk("t2_nwr", wq_addr.size(), 2);
    check_write("t2_w0", 0, 0, 8'h2C);
    check_write("t2_w1", 1, 1, 8'h48);
    pi_end = 1'b1;
    send(16'h00C3, 2'b00, 1'b0, 1'b0, 1'b1);
    pi_end = 1'b0;
    repeat (10) step();
    chk("t2_load_wins_nwr", wq_addr.size(), 3);
    check_write("t2_w2", 2, 2, 8'hC3);
    chk("t2_no_flush_ready", pi_ready, 1);

    // 32-bit fill-high, 24-bit fill-low, 8-bit low-half frames, continuing addresses
    send(16'hBEEF, 2'b11, 1'b0, 1'b1, 1'b1);
    repeat (33) step();
    send(16'hBEEF, 2'b10, 1'b0, 1'b0, 1'b1);
    repeat (25) step();
    send(16'hA53C, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (9) step();
    exp_d = '{8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hEF, 8'h3C};
    chk("t3_nwr", wq_addr.size(), 11);
    for (int k = 0; k < 8; k++) check_write("t3_w", 3 + k, 3 + k, int'(exp_d[k]));

    // Three back-to-back 16-bit frames with load held high
    do_reset();
    pi_data = 16'hA1B2; pi_length = 2'b01; pi_low = 1'b0; pi_fill = 1'b0; pi_msb = 1'b1;
    load = 1'b1;
    step();
    pi_data = 16'hC3D4;
    for (int c = 1; c <= 48; c++) begin
      chk("t4_so_valid", so_valid, 1);
      chk("t4_ready", pi_ready, (c % 16 == 0) ? 1 : 0);
      if (c == 17) pi_data = 16'hE5F6;
      if (c == 33) load = 1'b0;
      step();
    end
    chk("t4_valid_end", so_valid, 0);
    step();
    step();
    exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h00, 8'h00};
    chk("t4_nwr", wq_addr.size(), 6);
    for (int k = 0; k < 6; k++) check_write("t4_w", k, k, int'(exp_d[k]));

    // Three pixels then end-of-image flush to address 255
    do_reset();
    send(16'hABCD, 2'b10, 1'b0, 1'b1, 1'b1);
    repeat (24) step();
    pi_end = 1'b1;
    chk("t5_ready_idle", pi_ready, 1);
    step();
    pi_end = 1'b0;
    bad = 0;
    for (int c = 0; c < 260; c++) begin
      if (pi_ready !== 1'b0) bad++;
      step();
    end
    chk("t5_ready_low", bad, 0);
    chk("t5_nwr", wq_addr.size(), 256);
    check_write("t5_w0", 0, 0, 8'hAB);
    check_write("t5_w1", 1, 1, 8'hCD);
    check_write("t5_w2", 2, 2, 8'h00);
    bad = 0;
    for (int k = 3; k < wq_addr.size(); k++) begin
      if (wq_addr[k] != k || wq_data[k] != 0) bad++;
      if (k > 3 && wq_cyc[k] != wq_cyc[k-1] + 1) bad++;
    end
    chk("t5_flush_seq", bad, 0);
    chk("t5_flush_start", (wq_cyc.size() > 3) ? wq_cyc[3] - wq_cyc[2] : -1, 2);
    chk("t5_finish_time", (wq_cyc.size() == 256) ? finish_cyc - wq_cyc[255] : -1, 1);
    load = 1'b1;
    pi_data = 16'hFFFF;
    step();
    load = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (so_valid !== 1'b0) bad++;
      step();
    end
    chk("t5_load_ignored", bad, 0);
    chk("t5_no_more_wr", wq_addr.size(), 256);
    chk("t5_finish", pixel_finish, 1);
    chk("t5_ready_done", pi_ready, 0);

    // Reset in the middle of the second pixel of a frame
    do_reset();
    send(16'h7E81, 2'b01, 1'b0, 1'b0, 1'b1);
    repeat (12) step();
    chk("t6_pre_valid", so_valid, 1);
    chk("t6_pre_addr_log", wq_addr.size(), 1);
    reset = 1'b1;
    #1;
    chk("t6_so_valid", so_valid, 0);
    chk("t6_so_data", so_data, 0);
    chk("t6_pixel_wr", pixel_wr, 0);
    chk("t6_pixel_dataout", pixel_dataout, 0);
    chk("t6_pixel_addr", pixel_addr, 0);
    chk("t6_pi_ready", pi_ready, 1);
    #1;
    reset = 1'b0;
    clear_log();
    step();
    send(16'h5A00, 2'b00, 1'b1, 1'b0, 1'b1);
    repeat (10) step();
    chk("t6_nwr", wq_addr.size(), 1);
    check_write("t6_w0", 0, 0, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
